// File: rtl/id_ex_stage.sv
// Decode stage with ID/EX pipeline register, load-use stall detection and flush.
// Optional writeback-to-decode bypass is enabled by defining ID_WB_BYPASS_EN.
module id_ex_stage (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_VALID,
  input  logic [31:0] IF_INSTR,
  input  logic [31:0] IF_PC,
  output logic [4:0]  RF_ADDR1,
  output logic [4:0]  RF_ADDR2,
  input  logic [31:0] RF_DATA1,
  input  logic [31:0] RF_DATA2,
  input  logic        WB_WRITE,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  input  logic        FLUSH,
  output logic        STALL_OUT,
  output logic        EX_VALID,
  output logic [31:0] EX_PC,
  output logic [31:0] EX_RS1_DATA,
  output logic [31:0] EX_RS2_DATA,
  output logic [31:0] EX_IMM,
  output logic [4:0]  EX_RD,
  output logic [6:0]  EX_OPCODE,
  output logic [2:0]  EX_FUNCT3,
  output logic        EX_FUNCT7B5,
  output logic        EX_REGWRITE,
  output logic        EX_MEMREAD,
  output logic        EX_MEMWRITE
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        load_use;
  logic        capture;

  assign opcode   = IF_INSTR[6:0];
  assign rd       = IF_INSTR[11:7];
  assign funct3   = IF_INSTR[14:12];
  assign rs1      = IF_INSTR[19:15];
  assign rs2      = IF_INSTR[24:20];
  assign RF_ADDR1 = rs1;
  assign RF_ADDR2 = rs2;

  always_comb begin
    imm       = '0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_I, OP_JALR: begin
        imm       = {{20{IF_INSTR[31]}}, IF_INSTR[31:20]};
        reg_write = 1'b1;
        uses_rs1  = 1'b1;
      end
      OP_LOAD: begin
        imm       = {{20{IF_INSTR[31]}}, IF_INSTR[31:20]};
        reg_write = 1'b1;
        mem_read  = 1'b1;
        uses_rs1  = 1'b1;
      end
      OP_STORE: begin
        imm       = {{20{IF_INSTR[31]}}, IF_INSTR[31:25], IF_INSTR[11:7]};
        mem_write = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_BR: begin
        imm      = {{19{IF_INSTR[31]}}, IF_INSTR[31], IF_INSTR[7],
                    IF_INSTR[30:25], IF_INSTR[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm       = {IF_INSTR[31:12], 12'b0};
        reg_write = 1'b1;
      end
      OP_JAL: begin
        imm       = {{11{IF_INSTR[31]}}, IF_INSTR[31], IF_INSTR[19:12],
                     IF_INSTR[20], IF_INSTR[30:21], 1'b0};
        reg_write = 1'b1;
      end
      default: ;
    endcase
    // x0 is never a real destination
    if (rd == 5'd0) reg_write = 1'b0;
  end

`ifdef ID_WB_BYPASS_EN
  // Writeback lands in the register file this same edge, so the read port is stale.
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 :
                    (WB_WRITE && (WB_ADDR != 5'd0) && (WB_ADDR == rs1)) ? WB_DATA : RF_DATA1;
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 :
                    (WB_WRITE && (WB_ADDR != 5'd0) && (WB_ADDR == rs2)) ? WB_DATA : RF_DATA2;
`else
  logic unused_wb;
  assign unused_wb = &{1'b0, WB_WRITE, WB_ADDR, WB_DATA};
  assign rs1_data  = (rs1 == 5'd0) ? 32'd0 : RF_DATA1;
  assign rs2_data  = (rs2 == 5'd0) ? 32'd0 : RF_DATA2;
`endif

  // Handshake: IF_VALID offers an instruction; it is taken on the edge where
  // STALL_OUT=0 and FLUSH=0, otherwise upstream holds it and EX gets a bubble.
  assign load_use  = EX_VALID && EX_MEMREAD && (EX_RD != 5'd0) &&
                     ((uses_rs1 && (EX_RD == rs1)) || (uses_rs2 && (EX_RD == rs2)));
  assign STALL_OUT = IF_VALID && !FLUSH && load_use;
  assign capture   = IF_VALID && !FLUSH && !STALL_OUT;

  always_ff @(posedge CLK) begin
    if (RESET || !capture) begin
      EX_VALID    <= 1'b0;
      EX_PC       <= '0;
      EX_RS1_DATA <= '0;
      EX_RS2_DATA <= '0;
      EX_IMM      <= '0;
      EX_RD       <= '0;
      EX_OPCODE   <= '0;
      EX_FUNCT3   <= '0;
      EX_FUNCT7B5 <= 1'b0;
      EX_REGWRITE <= 1'b0;
      EX_MEMREAD  <= 1'b0;
      EX_MEMWRITE <= 1'b0;
    end else begin
      EX_VALID    <= 1'b1;
      EX_PC       <= IF_PC;
      EX_RS1_DATA <= rs1_data;
      EX_RS2_DATA <= rs2_data;
      EX_IMM      <= imm;
      EX_RD       <= rd;
      EX_OPCODE   <= opcode;
      EX_FUNCT3   <= funct3;
      EX_FUNCT7B5 <= IF_INSTR[30];
      EX_REGWRITE <= reg_write;
      EX_MEMREAD  <= mem_read;
      EX_MEMWRITE <= mem_write;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference decode model feeding an expected queue.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IF_VALID = 1'b0;
  logic [31:0] IF_INSTR = '0;
  logic [31:0] IF_PC = '0;
  logic [4:0]  RF_ADDR1, RF_ADDR2;
  logic [31:0] RF_DATA1 = '0;
  logic [31:0] RF_DATA2 = '0;
  logic        WB_WRITE = 1'b0;
  logic [4:0]  WB_ADDR = '0;
  logic [31:0] WB_DATA = '0;
  logic        FLUSH = 1'b0;
  logic        STALL_OUT;
  logic        EX_VALID, EX_FUNCT7B5, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE;
  logic [31:0] EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM;
  logic [4:0]  EX_RD;
  logic [6:0]  EX_OPCODE;
  logic [2:0]  EX_FUNCT3;

  id_ex_stage dut (
    .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC),
    .RF_ADDR1(RF_ADDR1), .RF_ADDR2(RF_ADDR2), .RF_DATA1(RF_DATA1), .RF_DATA2(RF_DATA2),
    .WB_WRITE(WB_WRITE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .FLUSH(FLUSH),
    .STALL_OUT(STALL_OUT), .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_RS1_DATA(EX_RS1_DATA),
    .EX_RS2_DATA(EX_RS2_DATA), .EX_IMM(EX_IMM), .EX_RD(EX_RD), .EX_OPCODE(EX_OPCODE),
    .EX_FUNCT3(EX_FUNCT3), .EX_FUNCT7B5(EX_FUNCT7B5), .EX_REGWRITE(EX_REGWRITE),
    .EX_MEMREAD(EX_MEMREAD), .EX_MEMWRITE(EX_MEMWRITE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [147:0] exp_q[$];
  logic         prev_valid = 1'b0;
  logic         prev_mr = 1'b0;
  logic [4:0]   prev_rd = '0;
  logic         last_stall = 1'b0;

  wire [147:0] got_vec = {EX_VALID, EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM, EX_RD,
                          EX_OPCODE, EX_FUNCT3, EX_FUNCT7B5, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE};

  task automatic chk(input string tag, input logic [147:0] got, input logic [147:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: ref_imm = {{20{i[31]}}, i[31:20]};
      7'b0100011: ref_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: ref_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: ref_imm = {i[31:12], 12'b0};
      7'b1101111: ref_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: ref_imm = '0;
    endcase
  endfunction

  function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] d);
    ref_src = d;
    if (a == 5'd0) ref_src = '0;
`ifdef ID_WB_BYPASS_EN
    else if (WB_WRITE && WB_ADDR != 5'd0 && WB_ADDR == a) ref_src = WB_DATA;
`endif
  endfunction

  function automatic logic [147:0] ref_ex(input logic [31:0] i, pc, d1, d2);
    logic [6:0] op;
    logic rw, mr, mw;
    op = i[6:0];
    rw = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111,
                     7'b1101111, 7'b1100111}) && (i[11:7] != 5'd0);
    mr = (op == 7'b0000011);
    mw = (op == 7'b0100011);
    ref_ex = {1'b1, pc, ref_src(i[19:15], d1), ref_src(i[24:20], d2), ref_imm(i),
              i[11:7], op, i[14:12], i[30], rw, mr, mw};
  endfunction

  function automatic logic ref_stall(input logic [31:0] i, input logic v, fl);
    logic u1, u2;
    u1 = i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    u2 = i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    ref_stall = v && !fl && prev_valid && prev_mr && prev_rd != 5'd0 &&
                ((u1 && prev_rd == i[19:15]) || (u2 && prev_rd == i[24:20]));
  endfunction

  // driver: present one cycle of stimulus, check stall, then score the EX register
  task automatic step(input logic [31:0] instr, pc, d1, d2, input logic v, fl, rst);
    logic [147:0] e;
    @(negedge CLK);
    IF_INSTR = instr; IF_PC = pc; RF_DATA1 = d1; RF_DATA2 = d2;
    IF_VALID = v; FLUSH = fl; RESET = rst;
    #1;
    last_stall = ref_stall(instr, v, fl);
    chk("stall", {147'd0, STALL_OUT}, {147'd0, last_stall});
    e = (rst || fl || !v || last_stall) ? '0 : ref_ex(instr, pc, d1, d2);
    exp_q.push_back(e);
    prev_valid = e[147];
    prev_mr = e[1];
    prev_rd = e[18:14];
    @(posedge CLK);
    #1;
    chk("ex_regs", got_vec, exp_q.pop_front());
  endtask

  localparam logic [31:0] ADDI  = 32'hFFC00293;
  localparam logic [31:0] SW    = 32'hFE20AC23;
  localparam logic [31:0] LW    = 32'h0000A303;
  localparam logic [31:0] ADD   = 32'h003303B3;
  localparam logic [31:0] ADDI3 = 32'h00118213;
  localparam logic [31:0] UNK   = 32'h000002FF;

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};

  initial begin
    logic [31:0] ri;
    @(posedge CLK);
    // reset held two cycles with a valid instruction on the input
    step(ADDI, 32'h100, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1);
    step(ADDI, 32'h100, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1);
    chk("reset_stall", {147'd0, STALL_OUT}, 148'd0);

    step(ADDI, 32'h100, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0);
    chk("addi_imm", {116'd0, EX_IMM}, {116'd0, 32'hFFFFFFFC});
    chk("addi_rd", {143'd0, EX_RD}, 148'd5);
    chk("addi_rw", {147'd0, EX_REGWRITE}, 148'd1);
    chk("addi_rs1", {116'd0, EX_RS1_DATA}, 148'd0);

    step(SW, 32'h104, 32'h1000, 32'hABCD, 1'b1, 1'b0, 1'b0);
    chk("sw_imm", {116'd0, EX_IMM}, {116'd0, 32'hFFFFFFF8});
    chk("sw_mw", {147'd0, EX_MEMWRITE}, 148'd1);
    chk("sw_rw", {147'd0, EX_REGWRITE}, 148'd0);

    // load-use: one stall cycle, one bubble, then the add
    step(LW, 32'h108, 32'h2000, 32'h0, 1'b1, 1'b0, 1'b0);
    step(ADD, 32'h10C, 32'h7, 32'h9, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_seen", {147'd0, last_stall}, 148'd1);
    chk("lu_bubble", {147'd0, EX_VALID}, 148'd0);
    step(ADD, 32'h10C, 32'h7, 32'h9, 1'b1, 1'b0, 1'b0);
    chk("lu_add_rd", {143'd0, EX_RD}, 148'd7);

    // flush wins over a pending load-use
    step(LW, 32'h110, 32'h2000, 32'h0, 1'b1, 1'b0, 1'b0);
    step(ADD, 32'h114, 32'h7, 32'h9, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", {147'd0, EX_VALID}, 148'd0);

    WB_WRITE = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h1C;
    step(ADDI3, 32'h118, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
`ifdef ID_WB_BYPASS_EN
    chk("bypass_rs1", {116'd0, EX_RS1_DATA}, 148'h1C);
`else
    chk("bypass_rs1", {116'd0, EX_RS1_DATA}, 148'd0);
`endif
    WB_WRITE = 1'b0;

    step(ADDI3, 32'h11C, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0);
    step(UNK, 32'h120, 32'h5, 32'h6, 1'b1, 1'b0, 1'b0);
    chk("unk_valid", {147'd0, EX_VALID}, 148'd1);

    // reset during a stall, then flush together with reset
    step(LW, 32'h124, 32'h2000, 32'h0, 1'b1, 1'b0, 1'b0);
    step(ADD, 32'h128, 32'h7, 32'h9, 1'b1, 1'b0, 1'b1);
    step(ADD, 32'h128, 32'h7, 32'h9, 1'b1, 1'b0, 1'b0);
    step(SW, 32'h12C, 32'h7, 32'h9, 1'b1, 1'b1, 1'b1);

    // random traffic with small register numbers to provoke hazards
    ri = LW;
    for (int n = 0; n < 80; n++) begin
      if (!last_stall) begin
        ri = $urandom;
        ri[6:0] = ops[$urandom_range(0, 9)];
        ri[11:7] = 5'($urandom_range(0, 4));
        ri[19:15] = 5'($urandom_range(0, 4));
        ri[24:20] = 5'($urandom_range(0, 4));
      end
      WB_WRITE = 1'($urandom_range(0, 1));
      WB_ADDR = 5'($urandom_range(0, 4));
      WB_DATA = $urandom;
      step(ri, 32'h200 + 32'(n * 4), $urandom, $urandom, $urandom_range(0, 7) != 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
